// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a one-cycle turnaround between grants; all outputs registered.
// Define BUS_ARB_TIMEOUT_EN to revoke a grant held for MAX_TENURE cycles while another requester waits.
module bus_arbiter #(
    parameter int N_REQ      = 4,
    parameter int MAX_TENURE = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         ack,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     bus_busy,
    output logic                     timeout
);
    localparam int W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || MAX_TENURE < 1 || MAX_TENURE > 255) begin : g_bad_param
        $error("bus_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t         state;
    logic [W-1:0]   last_owner;
    logic           pick_vld;
    logic [W-1:0]   pick_idx;
    logic [W-1:0]   cand;
    int             idx;

    // Walk offsets from N_REQ down to 1 so the nearest requester after last_owner wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = 0;
        cand     = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx  = (int'(last_owner) + i) % N_REQ;
            cand = W'(idx);
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam logic [7:0] TENURE_LIM = 8'(MAX_TENURE);
    logic [7:0] tenure;
    logic       rivals;

    assign rivals = |(req & ~ack);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ack        <= '0;
            grant_id   <= '0;
            bus_busy   <= 1'b0;
            last_owner <= W'(N_REQ - 1);
`ifdef BUS_ARB_TIMEOUT_EN
            tenure     <= 8'd0;
            timeout    <= 1'b0;
`endif
        end else begin
`ifdef BUS_ARB_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        ack      <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        grant_id <= pick_idx;
                        bus_busy <= 1'b1;
                        state    <= GRANT;
`ifdef BUS_ARB_TIMEOUT_EN
                        tenure   <= 8'd1;
`endif
                    end
                end
                GRANT: begin
                    if (!req[grant_id]) begin
                        ack        <= '0;
                        grant_id   <= '0;
                        bus_busy   <= 1'b0;
                        last_owner <= grant_id;
                        state      <= RELEASE;
`ifdef BUS_ARB_TIMEOUT_EN
                        tenure     <= 8'd0;
                    end else if (tenure == TENURE_LIM && rivals) begin
                        ack        <= '0;
                        grant_id   <= '0;
                        bus_busy   <= 1'b0;
                        last_owner <= grant_id;
                        state      <= RELEASE;
                        tenure     <= 8'd0;
                        timeout    <= 1'b1;
                    end else if (tenure != TENURE_LIM) begin
                        tenure     <= tenure + 8'd1;
`endif
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a per-cycle reference model plus directed scenarios with literal expectations.
module tb_bus_arbiter;
    localparam int N    = 4;
    localparam int MAXT = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] ack;
    logic [1:0] grant_id;
    logic       bus_busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    bus_arbiter #(.N_REQ(N), .MAX_TENURE(MAXT)) dut (
        .clk(clk), .reset(reset), .req(req), .ack(ack),
        .grant_id(grant_id), .bus_busy(bus_busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: owner index (-1 = bus free), cool = edges still reserved for turnaround.
    int m_owner, m_last, m_cool, m_held;
    bit m_to;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_owner = -1; m_last = N - 1; m_cool = 0; m_held = 0; m_to = 0;
        end else begin
            bit rel;
            rel  = 0;
            m_to = 0;
            if (m_owner >= 0) begin
                if (!req[m_owner]) rel = 1;
`ifdef BUS_ARB_TIMEOUT_EN
                else if (m_held >= MAXT && (req & ~(4'(1) << m_owner)) != 4'd0) begin
                    rel  = 1;
                    m_to = 1;
                end
`endif
                else if (m_held < MAXT) m_held++;
                if (rel) begin
                    m_last = m_owner; m_owner = -1; m_cool = 1; m_held = 0;
                end
            end else if (m_cool > 0) begin
                m_cool--;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (req[c] && m_owner < 0) begin
                        m_owner = c;
                        m_held  = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_ack", int'(ack), (m_owner >= 0) ? (1 << m_owner) : 0);
            chk("model_grant_id", int'(grant_id), (m_owner >= 0) ? m_owner : 0);
            chk("model_bus_busy", int'(bus_busy), (m_owner >= 0) ? 1 : 0);
            chk("model_timeout", int'(timeout), int'(m_to));
            chk("onehot_ack", ($countones(ack) <= 1) ? 1 : 0, 1);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[5];
        int exp_order[5];
        int gid;
        int n;
        exp_order = '{0, 1, 2, 3, 0};

        reset = 1'b1;
        req   = 4'b0000;
        repeat (3) @(negedge clk);
        reset   = 1'b0;
        started = 1'b1;

        // Single request, release and turnaround spacing
        chk("rst_ack", int'(ack), 0);
        chk("rst_gid", int'(grant_id), 0);
        chk("rst_busy", int'(bus_busy), 0);
        chk("rst_timeout", int'(timeout), 0);
        req = 4'b0001;
        @(negedge clk);
        chk("t1_ack", int'(ack), 1);
        chk("t1_gid", int'(grant_id), 0);
        chk("t1_busy", int'(bus_busy), 1);
        req = 4'b0000;
        @(negedge clk);
        chk("t1_release_ack", int'(ack), 0);
        req = 4'b0010;
        @(negedge clk);
        chk("t1_idle_ack", int'(ack), 0);
        @(negedge clk);
        chk("t1_next_ack", int'(ack), 2);
        chk("t1_next_gid", int'(grant_id), 1);

        // Rotation with all requesting, each owner backing off for two cycles
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (ack == 4'd0 && n < 20);
            if (ack == 4'd0) chk("t2_wait_grant", 0, 1);
            gid      = int'(grant_id);
            order[g] = gid;
            repeat (2) @(negedge clk);
            req[gid] = 1'b0;
            repeat (2) @(negedge clk);
            req[gid] = 1'b1;
        end
        for (int g = 0; g < 5; g++) chk($sformatf("t2_order%0d", g), order[g], exp_order[g]);

        // Owner keeps the bus while another requester rises
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        chk("t3_ack", int'(ack), 4);
        chk("t3_gid", int'(grant_id), 2);
        @(negedge clk);
        req = 4'b0110;
        repeat (3) begin
            @(negedge clk);
            chk("t3_hold_ack", int'(ack), 4);
        end
        req = 4'b0010;
        @(negedge clk);
        chk("t3_release_ack", int'(ack), 0);
        @(negedge clk);
        chk("t3_idle_ack", int'(ack), 0);
        @(negedge clk);
        chk("t3_next_ack", int'(ack), 2);

        // Asynchronous reset while requester 3 owns the bus
        do_reset();
        req = 4'b1000;
        @(negedge clk);
        chk("t4_ack", int'(ack), 8);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t4_async_ack", int'(ack), 0);
        chk("t4_async_busy", int'(bus_busy), 0);
        chk("t4_async_gid", int'(grant_id), 0);
        req = 4'b1001;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t4_after_ack", int'(ack), 1);
        chk("t4_after_gid", int'(grant_id), 0);

`ifdef BUS_ARB_TIMEOUT_EN
        // Tenure limit with a rival pending, then no rival
        do_reset();
        req = 4'b0011;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("t5_hold%0d_ack", c), int'(ack), 1);
            chk($sformatf("t5_hold%0d_to", c), int'(timeout), 0);
        end
        @(negedge clk);
        chk("t5_revoke_ack", int'(ack), 0);
        chk("t5_revoke_to", int'(timeout), 1);
        @(negedge clk);
        chk("t5_idle_ack", int'(ack), 0);
        chk("t5_idle_to", int'(timeout), 0);
        @(negedge clk);
        chk("t5_next_ack", int'(ack), 2);
        req = 4'b0001;
        repeat (3) @(negedge clk);
        chk("t5_solo_ack", int'(ack), 1);
        repeat (20) begin
            @(negedge clk);
            chk("t5_solo_hold_ack", int'(ack), 1);
            chk("t5_solo_hold_to", int'(timeout), 0);
        end
`else
        // Without the tenure limit a grant persists despite rivals
        do_reset();
        req = 4'b0011;
        repeat (14) begin
            @(negedge clk);
            chk("t5_nolimit_ack", int'(ack), 1);
            chk("t5_nolimit_to", int'(timeout), 0);
        end
`endif

        req = 4'b0000;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
